// File: rtl/ntt_cmd_sequencer.sv
// Decodes a held command word and issues a strided read sequence plus a delayed write sequence.
// Latency: reads begin the cycle after accept; writes trail reads by PIPE_LAT; done follows the last write by one cycle.
// Backpressure: none; command_we is level-sampled and ignored while busy or in the post-done guard window.
module ntt_cmd_sequencer #(
    parameter int LOG_COMMAND = 64,
    parameter int PIPE_LAT    = 4,
    parameter int GUARD_CYC   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LOG_COMMAND-1:0] command_in,
    input  logic                   command_we,
    output logic                   busy,
    output logic [4:0]             op_code,
    output logic                   rd_en,
    output logic [9:0]             rd_addr,
    output logic                   wr_en,
    output logic [9:0]             wr_addr,
    output logic                   done_ins_computation,
    output logic                   err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_GUARD
    } state_t;

    state_t                 r_state;
    logic [LOG_COMMAND-1:0] r_cmd;
    logic                   r_armed;
    logic [9:0]             r_src;
    logic [9:0]             r_dst;
    logic [10:0]            r_len;
    logic [3:0]             r_sl;
    logic [9:0]             r_idx;
    logic [4:0]             r_op;
    logic                   r_busy;
    logic                   r_rd_en;
    logic [9:0]             r_rd_addr;
    logic [PIPE_LAT-1:0]    r_pv;
    logic [9:0]             r_pa [PIPE_LAT];
    logic                   r_done;
    logic                   r_err;
    logic [2:0]             r_gcnt;

    logic [4:0]  w_op;
    logic [9:0]  w_src;
    logic [9:0]  w_dst;
    logic [10:0] w_len;
    logic [3:0]  w_sl;
    logic        w_legal;
    logic        w_accept;
    logic        w_last;
    logic [9:0]  w_idx_nxt;
    logic        w_pend;
    logic        w_active;

    assign w_op      = command_in[4:0];
    assign w_src     = command_in[14:5];
    assign w_dst     = command_in[24:15];
    assign w_len     = command_in[35:25];
    assign w_sl      = command_in[39:36];
    assign w_legal   = (w_op != 5'd0) && (w_op != 5'd31);
    // A word that was already executed only re-fires once command_we has dropped,
    // so a controller still holding the stale word after the guard cannot re-trigger.
    assign w_accept  = (r_state == S_IDLE) && command_we && w_legal
                       && (r_armed || (command_in != r_cmd));
    assign w_last    = ({1'b0, r_idx} == (r_len - 11'd1));
    assign w_idx_nxt = r_idx + 10'd1;
    assign w_active  = (r_state == S_RUN) || (r_state == S_DRAIN);

    always_comb begin
        w_pend = 1'b0;
        for (int k = 0; k < PIPE_LAT - 1; k++) begin
            w_pend = w_pend | r_pv[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cmd     <= '0;
            r_armed   <= 1'b1;
            r_src     <= '0;
            r_dst     <= '0;
            r_len     <= '0;
            r_sl      <= '0;
            r_idx     <= '0;
            r_op      <= '0;
            r_busy    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_pv      <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_gcnt    <= '0;
            for (int k = 0; k < PIPE_LAT; k++) begin
                r_pa[k] <= '0;
            end
        end else begin
            if (!command_we) begin
                r_armed <= 1'b1;
            end

            // Write pipe carries the finished write address alongside its valid bit.
            r_pv[0] <= r_rd_en;
            r_pa[0] <= r_dst + (r_idx << r_sl);
            for (int k = 1; k < PIPE_LAT; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pa[k] <= r_pa[k-1];
            end

            if (w_active && command_we && (command_in != r_cmd)) begin
                r_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cmd   <= command_in;
                        r_armed <= 1'b0;
                        r_src   <= w_src;
                        r_dst   <= w_dst;
                        r_len   <= w_len;
                        r_sl    <= w_sl;
                        r_op    <= w_op;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        if (w_len == 11'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_RUN;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= w_src;
                        end
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        r_rd_en <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_idx     <= w_idx_nxt;
                        r_rd_addr <= r_src + (w_idx_nxt << r_sl);
                    end
                end
                S_DRAIN: begin
                    // Valid bits are contiguous, so the output stage alone being full is the last write.
                    if (r_pv[PIPE_LAT-1] && !w_pend) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_gcnt  <= 3'(GUARD_CYC - 1);
                    r_state <= S_GUARD;
                end
                S_GUARD: begin
                    if (r_gcnt == 3'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt - 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy                 = r_busy;
    assign op_code              = r_op;
    assign rd_en                = r_rd_en;
    assign rd_addr              = r_rd_addr;
    assign wr_en                = r_pv[PIPE_LAT-1];
    assign wr_addr              = r_pa[PIPE_LAT-1];
    assign done_ins_computation = r_done;
    assign err                  = r_err;

endmodule
